// File: rtl/paddle_input_ctrl.sv
// rtl/paddle_input_ctrl.sv - debounced paddle up/down commands, press pulses and hold-to-accelerate speed
module paddle_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int ACCEL_FRAMES    = 16,
  parameter int MAX_SPEED       = 4,
  parameter int SPEED_W         = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         btn_raw_n,
  input  logic               frame_tick,
  output logic               up,
  output logic               down,
  output logic               up_pulse,
  output logic               down_pulse,
  output logic [SPEED_W-1:0] speed
);

  localparam int HOLD_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(ACCEL_FRAMES - 1);
  localparam logic [SPEED_W-1:0] SPEED_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [SPEED_W-1:0] SPEED_ONE = SPEED_W'(1);

  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DN} state_t;

  logic [1:0]            sync1;
  logic [1:0]            sync2;
  logic [1:0]            st;
  logic [1:0][CNT_W-1:0] cnt;
  logic                  pu;
  logic                  pd;
  logic                  up_q;
  logic                  down_q;
  state_t                state;
  state_t                state_nx;
  logic [SPEED_W-1:0]    speed_nx;
  logic [HOLD_W-1:0]     hold_cnt;
  logic [HOLD_W-1:0]     hold_nx;

  // Two-flop synchroniser per line; reset to the released (high) level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= btn_raw_n;
      sync2 <= sync1;
    end
  end

  // Per-line debounce: accept a new level only after it persists DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st  <= 2'b11;
      cnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          st[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Both buttons pressed together cancel out and read as idle.
  assign pu   = ~st[1];
  assign pd   = ~st[0];
  assign up   = pu & ~pd;
  assign down = pd & ~pu;

  assign up_pulse   = up & ~up_q;
  assign down_pulse = down & ~down_q;

  // Previous-cycle command levels for rising-edge pulse detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
    end else begin
      up_q   <= up;
      down_q <= down;
    end
  end

  // Speed FSM registers: direction state, current speed and frames held at this speed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      speed    <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nx;
      speed    <= speed_nx;
      hold_cnt <= hold_nx;
    end
  end

  // Next-state logic: a direction change restarts at speed 1 and wins over a same-cycle frame tick.
  always_comb begin
    state_nx = state;
    speed_nx = speed;
    hold_nx  = hold_cnt;
    if (!up && !down) begin
      state_nx = IDLE;
      speed_nx = '0;
      hold_nx  = '0;
    end else if ((up && state != HOLD_UP) || (down && state != HOLD_DN)) begin
      state_nx = up ? HOLD_UP : HOLD_DN;
      speed_nx = SPEED_ONE;
      hold_nx  = '0;
    end else if (frame_tick) begin
      if (hold_cnt == HOLD_LAST) begin
        hold_nx = '0;
        if (speed != SPEED_MAX) begin
          speed_nx = speed + 1'b1;
        end
      end else begin
        hold_nx = hold_cnt + 1'b1;
      end
    end
  end

endmodule
